// File: rtl/crc_stream_engine_if.sv
// Valid/ready word stream with a frame-end marker, shared by both sides of the CRC engine.
interface crc_stream_engine_if #(
    parameter int DATA_W = 8
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              last;

    modport master (output valid, data, last, input ready);
    modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: GENERATE appends the CRC to a frame, CHECK verifies the trailing CRC words.
//
// state  | meaning
// IDLE   | waiting for the first word of a frame, crc treated as INIT
// DATA   | forwarding words and folding them into crc
// APPEND | GENERATE only: emitting the K CRC words, MS word first
// DONE   | one cycle, done=1 and status registers updated
module crc_stream_engine #(
    parameter int               DATA_W = 8,
    parameter int               CRC_W  = 8,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'('h07),
    parameter logic [CRC_W-1:0] INIT   = '0,
    parameter logic [CRC_W-1:0] XOROUT = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode,
    crc_stream_engine_if.slave  s,
    crc_stream_engine_if.master m,
    output logic                done,
    output logic [CRC_W-1:0]    crc_value,
    output logic                crc_err,
    output logic                len_err
);
    localparam int K     = CRC_W / DATA_W;
    localparam int CNT_W = $clog2(K + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_APPEND, ST_DONE} state_t;

    state_t            state;
    logic              mode_q;
    logic              run;
    logic [CRC_W-1:0]  crc;
    logic [DATA_W-1:0] dly [K];
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  app_idx;

    logic              out_free;
    logic              accept;
    logic              mode_eff;
    logic              short_frame;
    logic [CRC_W-1:0]  crc_base;
    logic [CRC_W-1:0]  crc_gen;
    logic [CRC_W-1:0]  crc_chk;
    logic [CRC_W-1:0]  crc_out;
    logic [CRC_W-1:0]  rx_crc;
    logic [CNT_W-1:0]  cnt_base;
    logic [DATA_W-1:0] append_word;

    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c_in,
                                                  input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0] c;
        logic             fb;
        c = c_in;
        for (int b = DATA_W - 1; b >= 0; b--) begin
            fb = c[CRC_W-1] ^ d[b];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return c;
    endfunction

    // run keeps s_ready low until the first edge after reset release
    assign out_free    = !m.valid || m.ready;
    assign s.ready     = run && ((state == ST_IDLE) || (state == ST_DATA)) && out_free;
    assign accept      = s.valid && s.ready;
    assign mode_eff    = (state == ST_IDLE) ? mode : mode_q;
    assign crc_base    = (state == ST_IDLE) ? INIT : crc;
    assign cnt_base    = (state == ST_IDLE) ? '0 : cnt;
    assign crc_gen     = crc_step(crc_base, s.data);
    assign crc_chk     = (cnt_base == CNT_W'(K)) ? crc_step(crc_base, dly[K-1]) : crc_base;
    assign short_frame = (cnt_base != CNT_W'(K));
    assign crc_out     = crc ^ XOROUT;
    assign append_word = DATA_W'(crc_out >> (DATA_W * (K - 1 - int'(app_idx))));

    // Received CRC: the K-1 youngest delayed words plus the word being accepted.
    always_comb begin
        rx_crc = '0;
        rx_crc[DATA_W-1:0] = s.data;
        for (int i = 1; i < K; i++) begin
            rx_crc[i*DATA_W +: DATA_W] = dly[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            mode_q    <= 1'b0;
            run       <= 1'b0;
            crc       <= INIT;
            cnt       <= '0;
            app_idx   <= '0;
            m.valid   <= 1'b0;
            m.data    <= '0;
            m.last    <= 1'b0;
            done      <= 1'b0;
            crc_value <= '0;
            crc_err   <= 1'b0;
            len_err   <= 1'b0;
            for (int i = 0; i < K; i++) begin
                dly[i] <= '0;
            end
        end else begin
            run  <= 1'b1;
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DATA: begin
                    if (out_free) begin
                        m.valid <= accept;
                        if (accept) begin
                            m.data <= s.data;
                            m.last <= mode_eff && s.last;
                        end
                    end
                    if (accept) begin
                        mode_q <= mode_eff;
                        if (!mode_eff) begin
                            crc     <= crc_gen;
                            app_idx <= '0;
                            state   <= s.last ? ST_APPEND : ST_DATA;
                        end else begin
                            // Only words that have left the delay line are payload.
                            crc    <= crc_chk;
                            dly[0] <= s.data;
                            for (int i = K - 1; i > 0; i--) begin
                                dly[i] <= dly[i-1];
                            end
                            cnt <= short_frame ? cnt_base + 1'b1 : cnt_base;
                            if (s.last) begin
                                state     <= ST_DONE;
                                done      <= 1'b1;
                                crc_value <= crc_chk ^ XOROUT;
                                len_err   <= short_frame;
                                crc_err   <= !short_frame && (rx_crc != (crc_chk ^ XOROUT));
                            end else begin
                                state <= ST_DATA;
                            end
                        end
                    end
                end
                ST_APPEND: begin
                    if (out_free) begin
                        m.valid <= 1'b1;
                        m.data  <= append_word;
                        m.last  <= (app_idx == CNT_W'(K - 1));
                        if (app_idx == CNT_W'(K - 1)) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            crc_value <= crc_out;
                            crc_err   <= 1'b0;
                            len_err   <= 1'b0;
                        end else begin
                            app_idx <= app_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    if (out_free) begin
                        m.valid <= 1'b0;
                    end
                    crc   <= INIT;
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench for crc_stream_engine: CRC-8 (poly 07) and CRC-16 (poly 1021, init FFFF) instances.
module tb_crc_stream_engine;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] mode = '0;
    logic [1:0] sv = '0;
    logic [1:0] sl = '0;
    logic [1:0] mr_force = 2'b11;
    logic [1:0] rnd_bits = 2'b11;
    logic [1:0] rnd_en = '0;
    logic [1:0] mr;
    logic [7:0] sd [2];

    logic        done8, done16, ce8, ce16, le8, le16;
    logic [7:0]  cv8;
    logic [15:0] cv16;

    int nvec = 0;
    int nfail = 0;
    logic [8:0] oq0 [$];
    logic [8:0] oq1 [$];
    int done_n [2] = '{0, 0};
    int stall_err = 0;
    logic       stalled1 = 1'b0;
    logic [8:0] hold1 = '0;

    crc_stream_engine_if #(.DATA_W(8)) s8 ();
    crc_stream_engine_if #(.DATA_W(8)) m8 ();
    crc_stream_engine_if #(.DATA_W(8)) s16 ();
    crc_stream_engine_if #(.DATA_W(8)) m16 ();

    assign mr        = (rnd_en & rnd_bits) | (~rnd_en & mr_force);
    assign s8.valid  = sv[0];
    assign s8.data   = sd[0];
    assign s8.last   = sl[0];
    assign m8.ready  = mr[0];
    assign s16.valid = sv[1];
    assign s16.data  = sd[1];
    assign s16.last  = sl[1];
    assign m16.ready = mr[1];

    crc_stream_engine #(.DATA_W(8), .CRC_W(8), .POLY(8'h07), .INIT(8'h00), .XOROUT(8'h00)) dut8 (
        .clk(clk), .rst(rst), .mode(mode[0]), .s(s8.slave), .m(m8.master),
        .done(done8), .crc_value(cv8), .crc_err(ce8), .len_err(le8));

    crc_stream_engine #(.DATA_W(8), .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOROUT(16'h0000)) dut16 (
        .clk(clk), .rst(rst), .mode(mode[1]), .s(s16.slave), .m(m16.master),
        .done(done16), .crc_value(cv16), .crc_err(ce16), .len_err(le16));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_bits = 2'($urandom_range(0, 3));
    end

    // Inputs change only just after posedge, so negedge values hold through the next edge.
    always @(negedge clk) begin
        if (m8.valid && m8.ready) oq0.push_back({m8.last, m8.data});
        if (m16.valid && m16.ready) oq1.push_back({m16.last, m16.data});
        if (done8) done_n[0]++;
        if (done16) done_n[1]++;
        if (!rst) begin
            stalled1 = 1'b0;
        end else begin
            if (stalled1 && (!m16.valid || ({m16.last, m16.data} !== hold1))) stall_err++;
            stalled1 = m16.valid && !m16.ready;
            hold1    = {m16.last, m16.data};
        end
    end

    function automatic logic [15:0] ref_crc16(input logic [7:0] w [$]);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (w[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ w[i][b];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return c;
    endfunction

    task automatic send(input int d, input logic md, input logic [7:0] w [$],
                        input bit flip_mode, output bit ok);
        int t;
        ok = 1'b1;
        mode[d] = md;
        foreach (w[i]) begin
            sv[d] = 1'b1;
            sd[d] = w[i];
            sl[d] = (i == w.size() - 1);
            t = 0;
            @(negedge clk);
            while (!(d == 1 ? s16.ready : s8.ready)) begin
                t++;
                if (t > 300) begin
                    ok = 1'b0;
                    break;
                end
                @(negedge clk);
            end
            @(posedge clk);
            #1;
            if (!ok) break;
            if (flip_mode) mode[d] = ~md;
        end
        sv[d] = 1'b0;
        sl[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int n0, output bit ok);
        int t;
        t = 0;
        ok = 1'b1;
        while (done_n[d] == n0) begin
            @(negedge clk);
            t++;
            if (t > 500) begin
                ok = 1'b0;
                break;
            end
        end
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nvec++; if (s8.ready !== 1'b0) begin nfail++; $display("FAIL rst_s_ready got %b want 0", s8.ready); end
        nvec++; if (m8.valid !== 1'b0) begin nfail++; $display("FAIL rst_m_valid got %b want 0", m8.valid); end
        nvec++; if (m8.data !== 8'h00) begin nfail++; $display("FAIL rst_m_data got %h want 00", m8.data); end
        nvec++; if (m8.last !== 1'b0) begin nfail++; $display("FAIL rst_m_last got %b want 0", m8.last); end
        nvec++; if ({done8, ce8, le8} !== 3'b000) begin nfail++; $display("FAIL rst_status got %b want 000", {done8, ce8, le8}); end
        nvec++; if (cv16 !== 16'h0000) begin nfail++; $display("FAIL rst_crc_value got %h want 0000", cv16); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        nvec++; if (s8.ready !== 1'b0) begin nfail++; $display("FAIL rel_s_ready_early got %b want 0", s8.ready); end
        @(posedge clk);
        #1;
        nvec++; if ({s8.ready, s16.ready} !== 2'b11) begin nfail++; $display("FAIL rel_s_ready got %b want 11", {s8.ready, s16.ready}); end
    endtask

    task automatic test_gen_single();
        logic [7:0] fr [$];
        logic [8:0] exp [$];
        bit ok1, ok2;
        int n0;
        fr = '{8'hAB};
        exp = '{9'h0AB, 9'h158};
        oq0.delete();
        n0 = done_n[0];
        send(0, 1'b0, fr, 1'b0, ok1);
        wait_done(0, n0, ok2);
        nvec++; if (!(ok1 && ok2)) begin nfail++; $display("FAIL t1_progress got %b%b want 11", ok1, ok2); end
        nvec++; if (oq0.size() != exp.size()) begin nfail++; $display("FAIL t1_count got %0d want %0d", oq0.size(), exp.size()); end
        else foreach (exp[i]) begin
            nvec++; if (oq0[i] !== exp[i]) begin nfail++; $display("FAIL t1_word%0d got %h want %h", i, oq0[i], exp[i]); end
        end
        nvec++; if (cv8 !== 8'h58) begin nfail++; $display("FAIL t1_crc_value got %h want 58", cv8); end
        nvec++; if (done_n[0] - n0 != 1) begin nfail++; $display("FAIL t1_done_count got %0d want 1", done_n[0] - n0); end
    endtask

    task automatic test_gen_check();
        logic [7:0] fr [$];
        logic [8:0] exp [$];
        bit ok1, ok2;
        int n0;
        fr = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        exp.delete();
        foreach (fr[i]) exp.push_back({1'b0, fr[i]});
        exp.push_back(9'h1F4);
        oq0.delete();
        n0 = done_n[0];
        send(0, 1'b0, fr, 1'b0, ok1);
        wait_done(0, n0, ok2);
        nvec++; if (!(ok1 && ok2)) begin nfail++; $display("FAIL t2g_progress got %b%b want 11", ok1, ok2); end
        nvec++; if (oq0.size() != exp.size()) begin nfail++; $display("FAIL t2g_count got %0d want %0d", oq0.size(), exp.size()); end
        else foreach (exp[i]) begin
            nvec++; if (oq0[i] !== exp[i]) begin nfail++; $display("FAIL t2g_word%0d got %h want %h", i, oq0[i], exp[i]); end
        end
        nvec++; if (cv8 !== 8'hF4) begin nfail++; $display("FAIL t2g_crc_value got %h want F4", cv8); end

        fr.push_back(8'hF4);
        exp.delete();
        foreach (fr[i]) exp.push_back({(i == fr.size() - 1), fr[i]});
        oq0.delete();
        n0 = done_n[0];
        send(0, 1'b1, fr, 1'b0, ok1);
        wait_done(0, n0, ok2);
        nvec++; if (!(ok1 && ok2)) begin nfail++; $display("FAIL t2c_progress got %b%b want 11", ok1, ok2); end
        nvec++; if (oq0.size() != exp.size()) begin nfail++; $display("FAIL t2c_count got %0d want %0d", oq0.size(), exp.size()); end
        else foreach (exp[i]) begin
            nvec++; if (oq0[i] !== exp[i]) begin nfail++; $display("FAIL t2c_word%0d got %h want %h", i, oq0[i], exp[i]); end
        end
        nvec++; if ({ce8, le8} !== 2'b00) begin nfail++; $display("FAIL t2c_errs got %b want 00", {ce8, le8}); end
        nvec++; if (cv8 !== 8'hF4) begin nfail++; $display("FAIL t2c_crc_value got %h want F4", cv8); end

        fr[8] = 8'h38;
        n0 = done_n[0];
        send(0, 1'b1, fr, 1'b0, ok1);
        wait_done(0, n0, ok2);
        nvec++; if (!(ok1 && ok2)) begin nfail++; $display("FAIL t2e_progress got %b%b want 11", ok1, ok2); end
        nvec++; if ({ce8, le8} !== 2'b10) begin nfail++; $display("FAIL t2e_errs got %b want 10", {ce8, le8}); end
    endtask

    task automatic test_crc16_mode_hold();
        logic [7:0] fr [$];
        logic [8:0] exp [$];
        bit ok1, ok2;
        int n0;
        fr = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        exp.delete();
        foreach (fr[i]) exp.push_back({1'b0, fr[i]});
        exp.push_back(9'h029);
        exp.push_back(9'h1B1);
        oq1.delete();
        n0 = done_n[1];
        // mode flips to CHECK after the first word; the frame must stay GENERATE
        send(1, 1'b0, fr, 1'b1, ok1);
        mode[1] = 1'b0;
        wait_done(1, n0, ok2);
        nvec++; if (!(ok1 && ok2)) begin nfail++; $display("FAIL t3_progress got %b%b want 11", ok1, ok2); end
        nvec++; if (oq1.size() != exp.size()) begin nfail++; $display("FAIL t3_count got %0d want %0d", oq1.size(), exp.size()); end
        else foreach (exp[i]) begin
            nvec++; if (oq1[i] !== exp[i]) begin nfail++; $display("FAIL t3_word%0d got %h want %h", i, oq1[i], exp[i]); end
        end
        nvec++; if (cv16 !== 16'h29B1) begin nfail++; $display("FAIL t3_crc_value got %h want 29B1", cv16); end
    endtask

    task automatic test_len_err();
        logic [7:0] fr [$];
        bit ok1, ok2;
        int n0;
        fr = '{8'h11, 8'h22};
        oq1.delete();
        n0 = done_n[1];
        send(1, 1'b1, fr, 1'b0, ok1);
        wait_done(1, n0, ok2);
        nvec++; if (!(ok1 && ok2)) begin nfail++; $display("FAIL t4_progress got %b%b want 11", ok1, ok2); end
        nvec++; if ({le16, ce16} !== 2'b10) begin nfail++; $display("FAIL t4_errs got len=%b crc=%b want len=1 crc=0", le16, ce16); end
        nvec++; if (cv16 !== 16'hFFFF) begin nfail++; $display("FAIL t4_crc_value got %h want FFFF", cv16); end
        nvec++; if (done_n[1] - n0 != 1) begin nfail++; $display("FAIL t4_done_count got %0d want 1", done_n[1] - n0); end
        nvec++; if (oq1.size() != 2) begin nfail++; $display("FAIL t4_count got %0d want 2", oq1.size()); end
        else begin
            nvec++; if (oq1[1] !== 9'h122) begin nfail++; $display("FAIL t4_last_word got %h want 122", oq1[1]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] fr [$];
        logic [8:0] exp [$];
        logic [15:0] c;
        bit ok;
        int n0, len, t, acc_fail;
        oq1.delete();
        exp.delete();
        n0 = done_n[1];
        stall_err = 0;
        acc_fail = 0;
        rnd_en[1] = 1'b1;
        for (int f = 0; f < 100; f++) begin
            fr.delete();
            len = $urandom_range(1, 4);
            for (int i = 0; i < len; i++) fr.push_back(8'($urandom_range(0, 255)));
            c = ref_crc16(fr);
            foreach (fr[i]) exp.push_back({1'b0, fr[i]});
            exp.push_back({1'b0, c[15:8]});
            exp.push_back({1'b1, c[7:0]});
            send(1, 1'b0, fr, 1'b0, ok);
            if (!ok) acc_fail++;
        end
        t = 0;
        while ((done_n[1] - n0 < 100) && (t < 4000)) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        rnd_en[1] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        nvec++; if (acc_fail != 0) begin nfail++; $display("FAIL t5_accept_timeouts got %0d want 0", acc_fail); end
        nvec++; if (done_n[1] - n0 != 100) begin nfail++; $display("FAIL t5_done_count got %0d want 100", done_n[1] - n0); end
        nvec++; if (stall_err != 0) begin nfail++; $display("FAIL t5_stall_stability got %0d changes want 0", stall_err); end
        nvec++; if (oq1.size() != exp.size()) begin nfail++; $display("FAIL t5_count got %0d want %0d", oq1.size(), exp.size()); end
        else foreach (exp[i]) begin
            nvec++; if (oq1[i] !== exp[i]) begin nfail++; $display("FAIL t5_word%0d got %h want %h", i, oq1[i], exp[i]); end
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] fr [$];
        logic [8:0] exp [$];
        bit ok1, ok2;
        int n0;
        fr = '{8'h01, 8'h02, 8'h03};
        n0 = done_n[1];
        mr_force[1] = 1'b1;
        send(1, 1'b0, fr, 1'b0, ok1);
        @(posedge clk);
        #1;
        mr_force[1] = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        nvec++; if (!ok1) begin nfail++; $display("FAIL t6_progress got 0 want 1"); end
        nvec++; if ({m16.valid, m16.last, s16.ready, done16} !== 4'b0000) begin nfail++; $display("FAIL t6_ctrl got %b want 0000", {m16.valid, m16.last, s16.ready, done16}); end
        nvec++; if (m16.data !== 8'h00) begin nfail++; $display("FAIL t6_m_data got %h want 00", m16.data); end
        nvec++; if ({cv16, ce16, le16} !== 18'h0) begin nfail++; $display("FAIL t6_status got %h/%b%b want 0000/00", cv16, ce16, le16); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mr_force[1] = 1'b1;
        repeat (3) @(negedge clk);
        nvec++; if (done_n[1] != n0) begin nfail++; $display("FAIL t6_no_done got %0d pulses want 0", done_n[1] - n0); end
        @(posedge clk);
        #1;
        oq1.delete();
        fr = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        exp.delete();
        foreach (fr[i]) exp.push_back({1'b0, fr[i]});
        exp.push_back(9'h029);
        exp.push_back(9'h1B1);
        n0 = done_n[1];
        send(1, 1'b0, fr, 1'b0, ok1);
        wait_done(1, n0, ok2);
        nvec++; if (!(ok1 && ok2)) begin nfail++; $display("FAIL t6r_progress got %b%b want 11", ok1, ok2); end
        nvec++; if (oq1.size() != exp.size()) begin nfail++; $display("FAIL t6r_count got %0d want %0d", oq1.size(), exp.size()); end
        else foreach (exp[i]) begin
            nvec++; if (oq1[i] !== exp[i]) begin nfail++; $display("FAIL t6r_word%0d got %h want %h", i, oq1[i], exp[i]); end
        end
        nvec++; if (cv16 !== 16'h29B1) begin nfail++; $display("FAIL t6r_crc_value got %h want 29B1", cv16); end
    endtask

    initial begin
        sd[0] = 8'h00;
        sd[1] = 8'h00;
        test_reset();
        test_gen_single();
        test_gen_check();
        test_crc16_mode_hold();
        test_len_err();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired after %0d vectors", nvec);
        $fatal(1);
    end
endmodule
